// File: rtl/rs_alu_pkg.sv
// Shared constants for the ALU reservation station: default sizes,
// funct3 op classes, and a CDB tag-match helper.
package rs_alu_pkg;

  localparam int RS_SIZE_DEFAULT = 8;
  localparam int ROB_BIT_DEFAULT = 4;

  typedef enum logic [2:0] {
    OP_ADDSUB  = 3'b000,
    OP_SLL     = 3'b001,
    OP_SLT     = 3'b010,
    OP_SLTU    = 3'b011,
    OP_XOR     = 3'b100,
    OP_SRL_SRA = 3'b101,
    OP_OR      = 3'b110,
    OP_AND     = 3'b111
  } alu_op_e;

  // Tags are zero-extended to 32 bits so one helper serves any ROB width.
  function automatic logic tag_hit(input logic bus_valid,
                                   input logic [31:0] bus_tag,
                                   input logic [31:0] tag);
    return bus_valid && (bus_tag == tag);
  endfunction

endpackage

// File: rtl/rs_find_first.sv
// Lowest-index priority encoder: reports whether any request bit is set
// and the index of the lowest one.
module rs_find_first #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDX_W = $clog2(N);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = i[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: buffers issued instructions, snoops both CDBs
// for pending operands and dispatches the lowest ready entry each cycle.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEFAULT,
  parameter int ROB_BIT = ROB_BIT_DEFAULT
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  input  logic               flush,
  input  logic               issue_valid,
  input  logic [2:0]         issue_op,
  input  logic               issue_op_addition,
  input  logic               issue_has_imm,
  input  logic [4:0]         issue_imm,
  input  logic [ROB_BIT-1:0] issue_rob_entry,
  input  logic [31:0]        issue_vj,
  input  logic [31:0]        issue_vk,
  input  logic               issue_qj_valid,
  input  logic               issue_qk_valid,
  input  logic [ROB_BIT-1:0] issue_qj,
  input  logic [ROB_BIT-1:0] issue_qk,
  input  logic               cdb_alu_valid,
  input  logic [ROB_BIT-1:0] cdb_alu_rob,
  input  logic [31:0]        cdb_alu_val,
  input  logic               cdb_lsb_valid,
  input  logic [ROB_BIT-1:0] cdb_lsb_rob,
  input  logic [31:0]        cdb_lsb_val,
  output logic               full,
  output logic               alu_valid,
  output logic [31:0]        alu_vi,
  output logic [31:0]        alu_vj,
  output logic [4:0]         alu_imm,
  output logic [2:0]         alu_op,
  output logic               alu_has_imm,
  output logic               alu_op_addition,
  output logic [ROB_BIT-1:0] alu_rob_entry
);

  localparam int IDX_W = $clog2(RS_SIZE);

  // Entry state: busy is reset, payload is only meaningful while busy.
  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] qj_pend_q, qj_pend_d, qk_pend_q, qk_pend_d;
  logic [RS_SIZE-1:0] op_add_q, op_add_d, has_imm_q, has_imm_d;
  logic [2:0]         op_q[RS_SIZE], op_d[RS_SIZE];
  logic [4:0]         imm_q[RS_SIZE], imm_d[RS_SIZE];
  logic [31:0]        vj_q[RS_SIZE], vj_d[RS_SIZE];
  logic [31:0]        vk_q[RS_SIZE], vk_d[RS_SIZE];
  logic [ROB_BIT-1:0] qj_q[RS_SIZE], qj_d[RS_SIZE];
  logic [ROB_BIT-1:0] qk_q[RS_SIZE], qk_d[RS_SIZE];
  logic [ROB_BIT-1:0] rob_q[RS_SIZE], rob_d[RS_SIZE];

  // Registered dispatch bundle.
  logic               alu_valid_q, alu_valid_d;
  logic [31:0]        alu_vi_q, alu_vi_d, alu_vj_q, alu_vj_d;
  logic [4:0]         alu_imm_q, alu_imm_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic               alu_has_imm_q, alu_has_imm_d;
  logic               alu_op_add_q, alu_op_add_d;
  logic [ROB_BIT-1:0] alu_rob_q, alu_rob_d;

  logic [RS_SIZE-1:0] free_vec, ready_vec;
  logic               free_found, sel_found;
  logic [IDX_W-1:0]   free_idx, sel_idx;

  logic               iss_qj_pend, iss_qk_pend;
  logic [31:0]        iss_vj, iss_vk;

  assign free_vec  = ~busy_q;
  assign ready_vec = busy_q & ~qj_pend_q & ~qk_pend_q;
  assign full      = &busy_q;

  rs_find_first #(.N(RS_SIZE)) u_free_find (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_find_first #(.N(RS_SIZE)) u_ready_find (
    .req   (ready_vec),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // Issue-cycle operand bypass; the ALU bus wins if both buses match.
  always_comb begin
    iss_qj_pend = issue_qj_valid;
    iss_vj      = issue_vj;
    iss_qk_pend = issue_qk_valid && !issue_has_imm;
    iss_vk      = issue_vk;
    if (iss_qj_pend) begin
      if (tag_hit(cdb_alu_valid, 32'(cdb_alu_rob), 32'(issue_qj))) begin
        iss_qj_pend = 1'b0;
        iss_vj      = cdb_alu_val;
      end else if (tag_hit(cdb_lsb_valid, 32'(cdb_lsb_rob), 32'(issue_qj))) begin
        iss_qj_pend = 1'b0;
        iss_vj      = cdb_lsb_val;
      end
    end
    if (iss_qk_pend) begin
      if (tag_hit(cdb_alu_valid, 32'(cdb_alu_rob), 32'(issue_qk))) begin
        iss_qk_pend = 1'b0;
        iss_vk      = cdb_alu_val;
      end else if (tag_hit(cdb_lsb_valid, 32'(cdb_lsb_rob), 32'(issue_qk))) begin
        iss_qk_pend = 1'b0;
        iss_vk      = cdb_lsb_val;
      end
    end
  end

  // Next state: flush, then wakeup, dispatch from registered state, issue.
  always_comb begin
    busy_d        = busy_q;
    qj_pend_d     = qj_pend_q;
    qk_pend_d     = qk_pend_q;
    op_add_d      = op_add_q;
    has_imm_d     = has_imm_q;
    op_d          = op_q;
    imm_d         = imm_q;
    vj_d          = vj_q;
    vk_d          = vk_q;
    qj_d          = qj_q;
    qk_d          = qk_q;
    rob_d         = rob_q;
    alu_valid_d   = alu_valid_q;
    alu_vi_d      = alu_vi_q;
    alu_vj_d      = alu_vj_q;
    alu_imm_d     = alu_imm_q;
    alu_op_d      = alu_op_q;
    alu_has_imm_d = alu_has_imm_q;
    alu_op_add_d  = alu_op_add_q;
    alu_rob_d     = alu_rob_q;

    if (flush) begin
      busy_d      = '0;
      alu_valid_d = 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && qj_pend_q[i]) begin
          if (tag_hit(cdb_alu_valid, 32'(cdb_alu_rob), 32'(qj_q[i]))) begin
            vj_d[i]      = cdb_alu_val;
            qj_pend_d[i] = 1'b0;
          end else if (tag_hit(cdb_lsb_valid, 32'(cdb_lsb_rob), 32'(qj_q[i]))) begin
            vj_d[i]      = cdb_lsb_val;
            qj_pend_d[i] = 1'b0;
          end
        end
        if (busy_q[i] && qk_pend_q[i]) begin
          if (tag_hit(cdb_alu_valid, 32'(cdb_alu_rob), 32'(qk_q[i]))) begin
            vk_d[i]      = cdb_alu_val;
            qk_pend_d[i] = 1'b0;
          end else if (tag_hit(cdb_lsb_valid, 32'(cdb_lsb_rob), 32'(qk_q[i]))) begin
            vk_d[i]      = cdb_lsb_val;
            qk_pend_d[i] = 1'b0;
          end
        end
      end

      if (sel_found) begin
        busy_d[sel_idx] = 1'b0;
        alu_valid_d     = 1'b1;
        alu_vi_d        = vj_q[sel_idx];
        alu_vj_d        = vk_q[sel_idx];
        alu_imm_d       = imm_q[sel_idx];
        alu_op_d        = op_q[sel_idx];
        alu_has_imm_d   = has_imm_q[sel_idx];
        alu_op_add_d    = op_add_q[sel_idx];
        alu_rob_d       = rob_q[sel_idx];
      end else begin
        alu_valid_d = 1'b0;
      end

      // The free slot is never busy, so it cannot collide with the selected one.
      if (issue_valid && !full && free_found) begin
        busy_d[free_idx]    = 1'b1;
        op_d[free_idx]      = issue_op;
        op_add_d[free_idx]  = issue_op_addition;
        has_imm_d[free_idx] = issue_has_imm;
        imm_d[free_idx]     = issue_imm;
        vj_d[free_idx]      = iss_vj;
        qj_pend_d[free_idx] = iss_qj_pend;
        qj_d[free_idx]      = issue_qj;
        vk_d[free_idx]      = iss_vk;
        qk_pend_d[free_idx] = iss_qk_pend;
        qk_d[free_idx]      = issue_qk;
        rob_d[free_idx]     = issue_rob_entry;
      end
    end
  end

  // Control state and outputs, cleared immediately by reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q        <= '0;
      alu_valid_q   <= 1'b0;
      alu_vi_q      <= '0;
      alu_vj_q      <= '0;
      alu_imm_q     <= '0;
      alu_op_q      <= '0;
      alu_has_imm_q <= 1'b0;
      alu_op_add_q  <= 1'b0;
      alu_rob_q     <= '0;
    end else begin
      busy_q        <= busy_d;
      alu_valid_q   <= alu_valid_d;
      alu_vi_q      <= alu_vi_d;
      alu_vj_q      <= alu_vj_d;
      alu_imm_q     <= alu_imm_d;
      alu_op_q      <= alu_op_d;
      alu_has_imm_q <= alu_has_imm_d;
      alu_op_add_q  <= alu_op_add_d;
      alu_rob_q     <= alu_rob_d;
    end
  end

  // Entry payload; gated by busy so it needs no reset.
  always_ff @(posedge clk_in) begin
    qj_pend_q <= qj_pend_d;
    qk_pend_q <= qk_pend_d;
    op_add_q  <= op_add_d;
    has_imm_q <= has_imm_d;
    op_q      <= op_d;
    imm_q     <= imm_d;
    vj_q      <= vj_d;
    vk_q      <= vk_d;
    qj_q      <= qj_d;
    qk_q      <= qk_d;
    rob_q     <= rob_d;
  end

  assign alu_valid       = alu_valid_q;
  assign alu_vi          = alu_vi_q;
  assign alu_vj          = alu_vj_q;
  assign alu_imm         = alu_imm_q;
  assign alu_op          = alu_op_q;
  assign alu_has_imm     = alu_has_imm_q;
  assign alu_op_addition = alu_op_add_q;
  assign alu_rob_entry   = alu_rob_q;

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: expected dispatches go into a queue as
// stimulus is driven and are popped whenever alu_valid is seen.
module tb_rs_alu;
  import rs_alu_pkg::*;

  typedef struct packed {
    logic [31:0] vi;
    logic [31:0] vj;
    logic [4:0]  imm;
    logic [2:0]  op;
    logic        has_imm;
    logic        op_add;
    logic [3:0]  rob;
  } disp_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, flush, issue_valid;
  logic [2:0]  issue_op;
  logic        issue_op_addition, issue_has_imm;
  logic [4:0]  issue_imm;
  logic [3:0]  issue_rob_entry, issue_qj, issue_qk;
  logic [31:0] issue_vj, issue_vk;
  logic        issue_qj_valid, issue_qk_valid;
  logic        cdb_alu_valid, cdb_lsb_valid;
  logic [3:0]  cdb_alu_rob, cdb_lsb_rob;
  logic [31:0] cdb_alu_val, cdb_lsb_val;
  logic        full, alu_valid, alu_has_imm, alu_op_addition;
  logic [31:0] alu_vi, alu_vj;
  logic [4:0]  alu_imm;
  logic [2:0]  alu_op;
  logic [3:0]  alu_rob_entry;

  int checks = 0;
  int failures = 0;
  disp_t sb[$];

  rs_alu #(.RS_SIZE(8), .ROB_BIT(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_op_addition(issue_op_addition), .issue_has_imm(issue_has_imm),
    .issue_imm(issue_imm), .issue_rob_entry(issue_rob_entry),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_valid(issue_qj_valid), .issue_qk_valid(issue_qk_valid),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob(cdb_alu_rob), .cdb_alu_val(cdb_alu_val),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob(cdb_lsb_rob), .cdb_lsb_val(cdb_lsb_val),
    .full(full), .alu_valid(alu_valid), .alu_vi(alu_vi), .alu_vj(alu_vj),
    .alu_imm(alu_imm), .alu_op(alu_op), .alu_has_imm(alu_has_imm),
    .alu_op_addition(alu_op_addition), .alu_rob_entry(alu_rob_entry)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic disp_t cur_out();
    return '{vi: alu_vi, vj: alu_vj, imm: alu_imm, op: alu_op,
             has_imm: alu_has_imm, op_add: alu_op_addition, rob: alu_rob_entry};
  endfunction

  task automatic push_exp(input logic [31:0] vi, input logic [31:0] vj, input logic [4:0] imm,
                          input logic [2:0] op, input logic himm, input logic add,
                          input logic [3:0] rob);
    sb.push_back('{vi: vi, vj: vj, imm: imm, op: op, has_imm: himm, op_add: add, rob: rob});
  endtask

  // One clock: sample 1 time unit after the edge; stalled edges must hold
  // every output, other edges pop the scoreboard on alu_valid.
  task automatic cyc();
    logic  rdy_s, v_s;
    disp_t snap, e;
    rdy_s = rdy_in;
    v_s   = alu_valid;
    snap  = cur_out();
    @(posedge clk_in);
    #1;
    if (!rdy_s && rst_n_in) begin
      chk("stall_hold_fields", 128'(cur_out()), 128'(snap));
      chk("stall_hold_valid", 128'(alu_valid), 128'(v_s));
      $display("cycle t=%0t stall valid=%0b", $time, alu_valid);
    end else if (alu_valid) begin
      chk("dispatch_expected", 128'(sb.size() != 0), 128'(1'b1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("dispatch_bundle", 128'(cur_out()), 128'(e));
      end
      $display("dispatch t=%0t rob=%0d vi=%0h vj=%0h", $time, alu_rob_entry, alu_vi, alu_vj);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_op = 3'd0; issue_op_addition = 1'b0;
    issue_has_imm = 1'b0; issue_imm = 5'd0; issue_rob_entry = 4'd0;
    issue_vj = 32'd0; issue_vk = 32'd0; issue_qj_valid = 1'b0; issue_qk_valid = 1'b0;
    issue_qj = 4'd0; issue_qk = 4'd0;
    cdb_alu_valid = 1'b0; cdb_alu_rob = 4'd0; cdb_alu_val = 32'd0;
    cdb_lsb_valid = 1'b0; cdb_lsb_rob = 4'd0; cdb_lsb_val = 32'd0;
  endtask

  task automatic drive_issue(input logic [2:0] op, input logic add, input logic himm,
                             input logic [4:0] imm, input logic [3:0] rob,
                             input logic [31:0] vj, input logic qjv, input logic [3:0] qj,
                             input logic [31:0] vk, input logic qkv, input logic [3:0] qk);
    issue_valid = 1'b1; issue_op = op; issue_op_addition = add; issue_has_imm = himm;
    issue_imm = imm; issue_rob_entry = rob; issue_vj = vj; issue_qj_valid = qjv;
    issue_qj = qj; issue_vk = vk; issue_qk_valid = qkv; issue_qk = qk;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; flush = 1'b0;
    idle_inputs();
    #12;
    chk("reset_valid", 128'(alu_valid), 128'(1'b0));
    chk("reset_fields", 128'(cur_out()), 128'(0));
    chk("reset_full", 128'(full), 128'(1'b0));
    @(negedge clk_in);
    rst_n_in = 1'b1;
    cyc();

    // Ready issue: dispatch one edge after the issue edge, single pulse.
    drive_issue(OP_ADDSUB, 1'b0, 1'b0, 5'd0, 4'd3, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0);
    push_exp(32'd5, 32'd7, 5'd0, OP_ADDSUB, 1'b0, 1'b0, 4'd3);
    cyc();
    chk("ready_issue_edge_t", 128'(alu_valid), 128'(1'b0));
    idle_inputs();
    cyc();
    chk("ready_issue_edge_t1", 128'(alu_valid), 128'(1'b1));
    cyc();
    chk("ready_issue_pulse_end", 128'(alu_valid), 128'(1'b0));

    // Wakeup from the LSB bus.
    drive_issue(OP_ADDSUB, 1'b1, 1'b0, 5'd0, 4'd5, 32'd0, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0);
    cyc();
    idle_inputs();
    cyc();
    cyc();
    chk("wakeup_waiting", 128'(alu_valid), 128'(1'b0));
    cdb_lsb_valid = 1'b1; cdb_lsb_rob = 4'd2; cdb_lsb_val = 32'd10;
    push_exp(32'd10, 32'd1, 5'd0, OP_ADDSUB, 1'b0, 1'b1, 4'd5);
    cyc();
    chk("wakeup_edge_t", 128'(alu_valid), 128'(1'b0));
    idle_inputs();
    cyc();
    chk("wakeup_edge_t1", 128'(alu_valid), 128'(1'b1));
    cyc();

    // Issue-cycle bypass from the ALU bus.
    drive_issue(OP_XOR, 1'b0, 1'b0, 5'd0, 4'd7, 32'd0, 1'b1, 4'd4, 32'd9, 1'b0, 4'd0);
    cdb_alu_valid = 1'b1; cdb_alu_rob = 4'd4; cdb_alu_val = 32'h80;
    push_exp(32'h80, 32'd9, 5'd0, OP_XOR, 1'b0, 1'b0, 4'd7);
    cyc();
    idle_inputs();
    cyc();
    chk("bypass_edge_t1", 128'(alu_valid), 128'(1'b1));

    // Immediate form: a pending k tag must not block.
    drive_issue(OP_SLT, 1'b0, 1'b1, 5'h11, 4'd8, 32'd3, 1'b0, 4'd0, 32'h55, 1'b1, 4'd9);
    push_exp(32'd3, 32'h55, 5'h11, OP_SLT, 1'b1, 1'b0, 4'd8);
    cyc();
    idle_inputs();
    cyc();
    chk("imm_edge_t1", 128'(alu_valid), 128'(1'b1));
    cyc();

    // Fill all entries pending on tag 6.
    for (int i = 0; i < 8; i++) begin
      drive_issue(OP_OR, 1'b0, 1'b0, 5'd0, 4'(i), 32'd0, 1'b1, 4'd6, 32'(i * 3), 1'b0, 4'd0);
      cyc();
      if (i == 6) chk("full_at_seven", 128'(full), 128'(1'b0));
    end
    idle_inputs();
    chk("full_at_eight", 128'(full), 128'(1'b1));
    cdb_alu_valid = 1'b1; cdb_alu_rob = 4'd6; cdb_alu_val = 32'h66;
    for (int i = 0; i < 8; i++) push_exp(32'h66, 32'(i * 3), 5'd0, OP_OR, 1'b0, 1'b0, 4'(i));
    cyc();
    chk("full_wake_no_dispatch", 128'(alu_valid), 128'(1'b0));
    idle_inputs();
    cyc();
    chk("full_drops", 128'(full), 128'(1'b0));
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk("full_drain_rate", 128'(alu_valid), 128'(1'b1));
    end
    cyc();
    chk("full_drained", 128'(sb.size()), 128'(0));

    // Flush with three busy entries, one ready, and an issue in the flush cycle.
    drive_issue(OP_AND, 1'b0, 1'b0, 5'd0, 4'd1, 32'd0, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0);
    cyc();
    drive_issue(OP_AND, 1'b0, 1'b0, 5'd0, 4'd2, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9);
    cyc();
    drive_issue(OP_AND, 1'b0, 1'b0, 5'd0, 4'd3, 32'd4, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0);
    cyc();
    chk("flush_pre_valid", 128'(alu_valid), 128'(1'b0));
    flush = 1'b1;
    drive_issue(OP_AND, 1'b0, 1'b0, 5'd0, 4'd4, 32'd6, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0);
    cyc();
    chk("flush_valid", 128'(alu_valid), 128'(1'b0));
    chk("flush_full", 128'(full), 128'(1'b0));
    flush = 1'b0;
    idle_inputs();
    cdb_alu_valid = 1'b1; cdb_alu_rob = 4'd9; cdb_alu_val = 32'h99;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("flush_no_dispatch", 128'(alu_valid), 128'(1'b0));
    end
    idle_inputs();

    // Reset while a dispatch is out and another entry is ready.
    drive_issue(OP_SLL, 1'b0, 1'b0, 5'd0, 4'd10, 32'd11, 1'b0, 4'd0, 32'd12, 1'b0, 4'd0);
    push_exp(32'd11, 32'd12, 5'd0, OP_SLL, 1'b0, 1'b0, 4'd10);
    cyc();
    drive_issue(OP_SLL, 1'b0, 1'b0, 5'd0, 4'd11, 32'd13, 1'b0, 4'd0, 32'd14, 1'b0, 4'd0);
    cyc();
    chk("pre_reset_valid", 128'(alu_valid), 128'(1'b1));
    idle_inputs();
    #2 rst_n_in = 1'b0;
    #1;
    chk("async_reset_valid", 128'(alu_valid), 128'(1'b0));
    chk("async_reset_fields", 128'(cur_out()), 128'(0));
    chk("async_reset_full", 128'(full), 128'(1'b0));
    cyc();
    rst_n_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_reset_no_dispatch", 128'(alu_valid), 128'(1'b0));
    end

    // Stall: a matching broadcast while rdy_in is low is not captured.
    drive_issue(OP_SRL_SRA, 1'b1, 1'b0, 5'd0, 4'd12, 32'd0, 1'b1, 4'd11, 32'd2, 1'b0, 4'd0);
    cyc();
    idle_inputs();
    rdy_in = 1'b0;
    cdb_alu_valid = 1'b1; cdb_alu_rob = 4'd11; cdb_alu_val = 32'h1234;
    cyc();
    cyc();
    rdy_in = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_not_captured", 128'(alu_valid), 128'(1'b0));
    end
    cdb_lsb_valid = 1'b1; cdb_lsb_rob = 4'd11; cdb_lsb_val = 32'h777;
    push_exp(32'h777, 32'd2, 5'd0, OP_SRL_SRA, 1'b0, 1'b1, 4'd12);
    cyc();
    idle_inputs();
    cyc();
    chk("stall_late_wake", 128'(alu_valid), 128'(1'b1));

    // Stall while alu_valid is high: the pulse and bundle hold.
    drive_issue(OP_SLTU, 1'b0, 1'b0, 5'd0, 4'd13, 32'd21, 1'b0, 4'd0, 32'd22, 1'b0, 4'd0);
    push_exp(32'd21, 32'd22, 5'd0, OP_SLTU, 1'b0, 1'b0, 4'd13);
    cyc();
    idle_inputs();
    cyc();
    rdy_in = 1'b0;
    cyc();
    cyc();
    chk("stall_holds_pulse", 128'(alu_valid), 128'(1'b1));
    rdy_in = 1'b1;
    cyc();
    chk("after_stall_pulse_ends", 128'(alu_valid), 128'(1'b0));

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_alu.md
# rs_alu

Reservation station for integer ALU instructions in the out-of-order core. It sits between the issue/decode stage and the common ALU. It buffers up to `RS_SIZE` issued instructions and snoops both CDB broadcast buses to resolve pending operands. Each cycle it dispatches the lowest-index fully-ready entry to the ALU through a registered operand bundle.

## Interface
Parameters:
- `RS_SIZE`, 8: entry count; power of two, at least 2.
- `ROB_BIT`, `` `ROB_BIT ``: ROB tag width, from `Const.v`.

Ports:
- `clk_in` in 1: system clock.
- `rst_n_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: when low, all state and outputs hold.
- `flush` in 1: misprediction clear from the ROB.
- `issue_valid` in 1: issue request.
- `issue_op` in 3: funct3 class.
- `issue_op_addition` in 1: sub/sra select.
- `issue_has_imm` in 1: immediate form.
- `issue_imm` in 5: immediate.
- `issue_rob_entry` in `ROB_BIT`: destination tag.
- `issue_vj`, `issue_vk` in 32 each: operand values.
- `issue_qj_valid`, `issue_qk_valid` in 1 each: the operand is still pending.
- `issue_qj`, `issue_qk` in `ROB_BIT` each: producer tags.
- `cdb_alu_valid` in 1, `cdb_alu_rob` in `ROB_BIT`, `cdb_alu_val` in 32: ALU broadcast bus.
- `cdb_lsb_valid` in 1, `cdb_lsb_rob` in `ROB_BIT`, `cdb_lsb_val` in 32: load/store buffer broadcast bus.
- `full` out 1: no free entry; issue stage must not assert `issue_valid`.
- `alu_valid` out 1: dispatch strobe to the ALU's `valid`.
- `alu_vi`, `alu_vj` out 32: operands.
- `alu_imm` out 5, `alu_op` out 3, `alu_has_imm` out 1, `alu_op_addition` out 1, `alu_rob_entry` out `ROB_BIT`: instruction fields to the ALU.

## Operation
- **Entry contents:** busy, op, op_addition, has_imm, imm, vj, qj_pend, qj, vk, qk_pend, qk, rob.
- **Issue:**
  - Taken when `issue_valid` is high and `full` is low.
  - Written into the lowest-index non-busy entry.
- **Issue bypass:**
  - A pending issue operand whose tag matches a valid CDB in the same cycle is captured as ready, with the CDB value.
  - If `issue_has_imm` is set, the k operand is ready regardless of `issue_qk_valid`.
- **Wakeup:**
  - Every busy entry with a pending operand whose tag equals a valid CDB tag captures that value and clears its pending flag.
  - Both buses are checked independently.
  - Equal tags on both buses cannot occur (ROB tags are unique); on that condition the ALU bus takes priority.
- **Select:**
  - Combinational find-first over busy entries with both pending flags clear, evaluated on registered state.
  - On a hit: the `alu_*` outputs load that entry's fields (`alu_vj` ← vk), `alu_valid` is set to 1, and the entry's busy bit clears.
  - With no hit, `alu_valid` is set to 0.
- **Same-cycle events:**
  - Issue and dispatch may occur in the same cycle.
  - An entry freed by dispatch is not visible as free until the next cycle.
  - An issued entry is never selected in its own issue cycle.
- **`full`:** combinational; asserted when all busy bits are set.
- **Flush:**
  - At the next edge all busy bits clear and `alu_valid` goes to 0.
  - Any issue or dispatch in that cycle is discarded.
  - Flush has priority over everything except reset.
- **Reset (`rst_n_in` low):**
  - Immediately clears all busy bits.
  - All outputs go to 0: `alu_valid`, `alu_vi`, `alu_vj`, `alu_imm`, `alu_op`, `alu_has_imm`, `alu_op_addition`, `alu_rob_entry`.
  - `full` = 0.
  - Reset mid-operation loses all entries; no pending dispatch survives.
- **`rdy_in` low:** no issue, wakeup or dispatch; all outputs hold. CDB broadcasts in stalled cycles are not captured.

## Timing
- **Issue to dispatch, operands ready at issue:** issue sampled at edge t; `alu_valid` is high after edge t+1.
- **Wakeup to dispatch:** CDB valid at edge t wakes the entry; dispatch is registered at edge t+1.
- **Issue-cycle bypass:** same latency as issue with operands ready (`alu_valid` after edge t+1).
- **Throughput:** one dispatch per cycle.
- **`alu_valid`:** a single-cycle pulse per instruction.

## Structure
- **`Const.v`:** holds `ROB_BIT`, the default `RS_SIZE` and the funct3 op encodings (AddSub..And), shared with the ALU and decoder.
- **Sub-module `rs_find_first`:** parameterized lowest-index priority encoder producing a found flag and an index. It is instantiated twice, once for free-slot search and once for ready-entry select.

## Test plan
- **Ready issue:** after reset, issue ADD vj=5, vk=7, rob=3, no pending operands → `alu_valid` high for exactly one cycle after edge t+1, with `alu_vi`=5, `alu_vj`=7, `alu_rob_entry`=3.
- **Wakeup:** issue SUB with qj=2 pending, vk=1; a later `cdb_lsb` broadcasts rob=2, val=10 → dispatch the next cycle with `alu_vi`=10, `alu_vj`=1, `alu_op_addition`=1.
- **Issue bypass and immediate form:** issue with qj=4 while `cdb_alu` broadcasts rob=4, val=0x80 → entry is ready immediately and dispatches `alu_vi`=0x80. A has_imm issue with `issue_qk_valid`=1 is not blocked.
- **Full and priority:** fill all 8 entries with operands pending on tag 6 → `full`=1. Broadcast tag 6 → entries dispatch in index order 0..7, one per cycle, and `full` drops after the first dispatch.
- **Flush:** flush while 3 entries are busy and one is ready → `alu_valid`=0 at the next edge, `full`=0, and no later dispatch of the flushed entries.
- **Reset and stall:** assert `rst_n_in` low mid-dispatch → outputs are 0 asynchronously. Hold `rdy_in` low while a CDB matches → the tag is not captured and outputs hold.
